// File: rtl/mem_responder_if.sv
// Request/response bundle between a cache master and the backing-memory responder.
//   s_rqst  request ID (0 = idle), held until a final response
//   s_trsc  coherency transaction code (informational only)
//   s_strb  byte write strobe, nonzero selects a write
//   s_addr  physical byte address
//   s_wdat  write data
//   s_resp  response ID (0 = none)
//   s_miss  nonzero = read accepted, handle of pending callback; 0 = final
//   s_ofst  address of the request being responded to
//   s_rdat  read data for a final read response
interface mem_responder_if #(
    parameter int unsigned blk = 64
);
    logic [7:0]       s_rqst;
    logic [7:0]       s_trsc;
    logic [blk-1:0]   s_strb;
    logic [63:0]      s_addr;
    logic [blk*8-1:0] s_wdat;
    logic [7:0]       s_resp;
    logic [7:0]       s_miss;
    logic [63:0]      s_ofst;
    logic [blk*8-1:0] s_rdat;

    modport master (
        output s_rqst, s_trsc, s_strb, s_addr, s_wdat,
        input  s_resp, s_miss, s_ofst, s_rdat
    );

    modport slave (
        input  s_rqst, s_trsc, s_strb, s_addr, s_wdat,
        output s_resp, s_miss, s_ofst, s_rdat
    );
endinterface

// File: rtl/mem_responder.sv
// Backing-memory responder: slave end of the rqst/resp/miss protocol.
// Writes are acknowledged in the same cycle; reads are acknowledged with a
// miss handle and completed by an in-order callback lat cycles later, carrying
// a snapshot of the line taken at acceptance.
//   clk     clock
//   rst     synchronous active-high reset (queue only; array keeps contents)
//   flmask  flush ignore mask
//   flrqst  flush request ID
//   bus     slave side of mem_responder_if
module mem_responder #(
    parameter int unsigned blk   = 64,
    parameter int unsigned depth = 1024,
    parameter int unsigned lat   = 8,
    parameter int unsigned qsz   = 4,
    parameter logic [7:0]  hbase = 8'h80
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     flmask,
    input  logic [7:0]     flrqst,
    mem_responder_if.slave bus
);
    localparam int unsigned   OW    = $clog2(blk);
    localparam int unsigned   AW    = $clog2(depth);
    localparam int unsigned   PW    = (qsz > 1) ? $clog2(qsz) : 1;
    localparam int unsigned   CW    = (lat > 1) ? $clog2(lat) : 1;
    localparam logic [PW:0]   QFULL = (PW+1)'(qsz);
    localparam logic [PW-1:0] PLAST = PW'(qsz - 1);
    // Loaded with lat-1: the counter reaches zero exactly lat cycles after the ack.
    localparam logic [CW-1:0] CNT0  = CW'(lat - 1);

    logic [blk*8-1:0] mem_q [depth];

    logic [qsz-1:0]   vld_q, vld_d;
    logic [7:0]       id_q  [qsz];
    logic [7:0]       id_d  [qsz];
    logic [63:0]      adr_q [qsz];
    logic [63:0]      adr_d [qsz];
    logic [blk*8-1:0] dat_q [qsz];
    logic [blk*8-1:0] dat_d [qsz];
    logic [CW-1:0]    cnt_q [qsz];
    logic [CW-1:0]    cnt_d [qsz];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      occ_q, occ_d;

    logic [AW-1:0]    lidx;
    logic             req, is_wr, req_fl, hit, full, empty;
    logic             cb, skip, deq, wr_ack, rd_re, rd_new;
    logic [PW-1:0]    hit_slot;

    logic             unused_trsc;
    assign unused_trsc = ^bus.s_trsc;

    function automatic logic flushed(input logic [7:0] id, input logic [7:0] frq,
                                     input logic [7:0] fmk);
        return ((id ^ frq) & ~fmk) == 8'h00;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + 1'b1;
    endfunction

    // Request decode and queue status.
    always_comb begin
        lidx     = bus.s_addr[OW +: AW];
        req      = !rst && (bus.s_rqst != 8'h00);
        is_wr    = bus.s_strb != '0;
        req_fl   = flushed(bus.s_rqst, flrqst, flmask);
        hit      = 1'b0;
        hit_slot = '0;
        for (int unsigned i = 0; i < qsz; i++) begin
            if (vld_q[i] && (id_q[i] == bus.s_rqst)) begin
                hit      = 1'b1;
                hit_slot = PW'(i);
            end
        end
        full  = (occ_q == QFULL);
        empty = (occ_q == '0);
        // A head being flushed this cycle is invalidated, never called back.
        cb    = !rst && !empty && vld_q[head_q] && (cnt_q[head_q] == '0)
                && !flushed(id_q[head_q], flrqst, flmask);
        // Flushed entries stay in place until they reach the head, then are dropped silently.
        skip  = !rst && !empty && !vld_q[head_q];
        deq   = cb || skip;
        wr_ack = req && is_wr  && !cb && !req_fl;
        rd_re  = req && !is_wr && !cb && !req_fl && hit;
        rd_new = req && !is_wr && !cb && !req_fl && !hit && !full;
    end

    // Response port: callback has priority over any ack.
    always_comb begin
        bus.s_resp = '0;
        bus.s_miss = '0;
        bus.s_ofst = '0;
        bus.s_rdat = '0;
        if (cb) begin
            bus.s_resp = id_q[head_q];
            bus.s_ofst = adr_q[head_q];
            bus.s_rdat = dat_q[head_q];
        end else if (wr_ack) begin
            bus.s_resp = bus.s_rqst;
            bus.s_ofst = bus.s_addr;
        end else if (rd_re) begin
            bus.s_resp = bus.s_rqst;
            bus.s_miss = hbase | 8'(hit_slot);
            bus.s_ofst = bus.s_addr;
        end else if (rd_new) begin
            bus.s_resp = bus.s_rqst;
            bus.s_miss = hbase | 8'(tail_q);
            bus.s_ofst = bus.s_addr;
        end
    end

    // Queue next state.
    always_comb begin
        vld_d  = vld_q;
        id_d   = id_q;
        adr_d  = adr_q;
        dat_d  = dat_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        for (int unsigned i = 0; i < qsz; i++) begin
            if (vld_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
            if (vld_q[i] && flushed(id_q[i], flrqst, flmask)) vld_d[i] = 1'b0;
        end
        if (deq) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        if (rd_new) begin
            vld_d[tail_q] = 1'b1;
            id_d[tail_q]  = bus.s_rqst;
            adr_d[tail_q] = bus.s_addr;
            dat_d[tail_q] = mem_q[lidx];
            cnt_d[tail_q] = CNT0;
            tail_d        = ptr_inc(tail_q);
        end
        occ_d = occ_q + {{PW{1'b0}}, rd_new} - {{PW{1'b0}}, deq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Entry payload is only meaningful while its valid bit is set.
    always_ff @(posedge clk) begin
        id_q  <= id_d;
        adr_q <= adr_d;
        dat_q <= dat_d;
        cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (wr_ack) begin
            for (int unsigned b = 0; b < blk; b++) begin
                if (bus.s_strb[b]) mem_q[lidx][b*8 +: 8] <= bus.s_wdat[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a table of single-cycle write
// vectors followed by hand-written multi-cycle read/callback sequences.
module tb_mem_responder;
    localparam int unsigned BLK = 64;
    localparam int unsigned LAT = 8;
    typedef logic [BLK*8-1:0] line_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] flmask, flrqst;

    mem_responder_if #(.blk(BLK)) bus ();

    mem_responder #(
        .blk(BLK), .depth(1024), .lat(LAT), .qsz(4), .hbase(8'h80)
    ) dut (
        .clk(clk), .rst(rst), .flmask(flmask), .flrqst(flrqst), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  rqst;
        logic [63:0] strb;
        logic [63:0] addr;
        line_t       wdat;
        logic [7:0]  fl;
        logic [7:0]  exp_resp;
    } vec_t;
    vec_t tv[6];

    line_t pa, pb, pc, pap, pbp;

    function automatic line_t pat(input logic [7:0] seed);
        line_t v;
        for (int i = 0; i < BLK; i++) v[i*8 +: 8] = seed + 8'(i*13);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.s_rqst = 8'h00;
        bus.s_trsc = 8'h00;
        bus.s_strb = '0;
        bus.s_addr = '0;
        bus.s_wdat = '0;
    endtask

    // One-cycle read presentation that must be acked with the given handle.
    task automatic rd_ack(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] miss);
        bus.s_rqst = id;
        bus.s_trsc = 8'h01;
        bus.s_strb = '0;
        bus.s_addr = addr;
        #1;
        chk("ack_resp", bus.s_resp, id);
        chk("ack_miss", bus.s_miss, miss);
        chk("ack_ofst", bus.s_ofst, addr);
        @(negedge clk);
        idle();
    endtask

    // Cycles from..to with idle inputs; exactly one callback expected at cb_at.
    task automatic watch(input int from, input int to, input int cb_at, input logic [7:0] id,
                         input logic [63:0] addr, input line_t dat);
        for (int k = from; k <= to; k++) begin
            #1;
            if (k == cb_at) begin
                chk("cb_resp", bus.s_resp, id);
                chk("cb_miss", bus.s_miss, 8'h00);
                chk("cb_ofst", bus.s_ofst, addr);
                chk("cb_rdat", bus.s_rdat, dat);
            end else begin
                chk("quiet_resp", bus.s_resp, 8'h00);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pa  = pat(8'h11);
        pb  = pat(8'h37);
        pc  = pat(8'h6B);
        pap = pa; pap[7:0]     = 8'h5A;
        pbp = pb; pbp[511:504] = 8'hC3;

        // 0x12040 aliases line 0x81 with 0x2040 (1024-line array).
        tv[0] = '{8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1000,  pa,            8'h00, 8'h05};
        tv[1] = '{8'h09, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2040,  pb,            8'h00, 8'h09};
        tv[2] = '{8'h03, 64'h0000_0000_0000_0001, 64'h1000,  {64{8'h5A}},   8'h00, 8'h03};
        tv[3] = '{8'h04, 64'h8000_0000_0000_0000, 64'h12040, {64{8'hC3}},   8'h00, 8'h04};
        tv[4] = '{8'h30, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2040,  line_t'(0),    8'h30, 8'h00};
        tv[5] = '{8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3000,  pc,            8'h00, 8'h00};

        rst = 1'b1; flmask = 8'h00; flrqst = 8'h00;
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_resp", bus.s_resp, 8'h00);
        chk("rst_miss", bus.s_miss, 8'h00);
        rst = 1'b0;
        #1;
        chk("idle_resp", bus.s_resp, 8'h00);
        chk("idle_miss", bus.s_miss, 8'h00);
        @(negedge clk);

        // Table: same-cycle write responses (and a flushed write being dropped).
        for (int i = 0; i < 6; i++) begin
            bus.s_rqst = tv[i].rqst;
            bus.s_strb = tv[i].strb;
            bus.s_addr = tv[i].addr;
            bus.s_wdat = tv[i].wdat;
            flrqst     = tv[i].fl;
            #1;
            chk("tv_resp", bus.s_resp, tv[i].exp_resp);
            chk("tv_miss", bus.s_miss, 8'h00);
            if (tv[i].exp_resp != 8'h00) begin
                chk("tv_ofst", bus.s_ofst, tv[i].addr);
                chk("tv_rdat", bus.s_rdat, '0);
            end
            @(negedge clk);
        end
        idle();
        flrqst = 8'h00;

        // Read after full + partial write: handle 0x80, callback lat cycles later.
        rd_ack(8'h06, 64'h1000, 8'h80);
        watch(1, 9, 8, 8'h06, 64'h1000, pap);

        // Snapshot: a write after acceptance is not visible to that read.
        rd_ack(8'h0A, 64'h2040, 8'h81);
        bus.s_rqst = 8'h0B;
        bus.s_strb = '1;
        bus.s_addr = 64'h2040;
        bus.s_wdat = pc;
        #1;
        chk("snap_wr_resp", bus.s_resp, 8'h0B);
        chk("snap_wr_miss", bus.s_miss, 8'h00);
        @(negedge clk);
        idle();
        watch(2, 8, 8, 8'h0A, 64'h2040, pbp);
        rd_ack(8'h0C, 64'h2040, 8'h82);
        watch(1, 8, 8, 8'h0C, 64'h2040, pc);

        // Re-present: same handle every cycle, one callback.
        for (int k = 0; k < 5; k++) begin
            bus.s_rqst = 8'h07;
            bus.s_addr = 64'h1000;
            #1;
            chk("rep_resp", bus.s_resp, 8'h07);
            chk("rep_miss", bus.s_miss, 8'h83);
            @(negedge clk);
        end
        idle();
        watch(5, 9, 8, 8'h07, 64'h1000, pap);

        // Full queue; the four callbacks occupy consecutive cycles and block
        // acks, so ID 5 is accepted right after the last of them.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) rd_ack(8'(i), 64'h1000, 8'(8'h80 + i - 1));
        bus.s_rqst = 8'h05;
        bus.s_addr = 64'h2040;
        for (int k = 4; k <= 12; k++) begin
            #1;
            if (k < 8) begin
                chk("full_hold", bus.s_resp, 8'h00);
            end else if (k < 12) begin
                chk("full_cb_id", bus.s_resp, 8'(k - 7));
                chk("full_cb_miss", bus.s_miss, 8'h00);
                chk("full_cb_ofst", bus.s_ofst, 64'h1000);
                chk("full_cb_rdat", bus.s_rdat, pap);
            end else begin
                chk("full_ack5_resp", bus.s_resp, 8'h05);
                chk("full_ack5_miss", bus.s_miss, 8'h80);
            end
            @(negedge clk);
        end
        idle();
        watch(13, 21, 20, 8'h05, 64'h2040, pc);

        // Exact-ID flush: 0x11 dropped, 0x12 still called back.
        rd_ack(8'h11, 64'h1000, 8'h81);
        rd_ack(8'h12, 64'h2040, 8'h82);
        flrqst     = 8'h11;
        bus.s_rqst = 8'h11;
        bus.s_addr = 64'h1000;
        #1;
        chk("fl_req_resp", bus.s_resp, 8'h00);
        @(negedge clk);
        idle();
        flrqst = 8'h00;
        watch(3, 12, 9, 8'h12, 64'h2040, pc);

        // Masked flush: low-nibble match drops 0x21 and 0x31, keeps 0x22.
        rd_ack(8'h21, 64'h1000, 8'h83);
        rd_ack(8'h22, 64'h2040, 8'h80);
        rd_ack(8'h31, 64'h1000, 8'h81);
        flmask = 8'hF0;
        flrqst = 8'h01;
        #1;
        chk("flm_resp", bus.s_resp, 8'h00);
        @(negedge clk);
        flmask = 8'h00;
        flrqst = 8'h00;
        watch(4, 14, 9, 8'h22, 64'h2040, pc);

        // Reset with three reads pending: no callbacks, array retained.
        rd_ack(8'h41, 64'h1000, 8'h82);
        rd_ack(8'h42, 64'h2040, 8'h83);
        rd_ack(8'h43, 64'h1000, 8'h80);
        rst = 1'b1;
        #1;
        chk("rst_mid_resp", bus.s_resp, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        watch(0, 2*LAT - 1, -1, 8'h00, 64'h0, '0);
        rd_ack(8'h44, 64'h1000, 8'h80);
        watch(1, 9, 8, 8'h44, 64'h1000, pap);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
